// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bundle for the fetch sequencer.
// The master side issues requests; the slave (memory) answers with ready/rdata.
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Sequenced instruction fetch over a multi-cycle, handshaked instruction memory.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT timeout with retry and sticky fetch_err.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   fetch_sequencer_if.master         imem,
   input  logic                      stall,
   input  logic                      Br_taken,
   input  logic [31:0]               Br_offset,
   output logic [31:0]               PC,
   output logic [31:0]               Instruction,
   output logic                      inst_valid,
   output logic                      flush,
   output logic                      fetch_err
);

   typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] pend_target_q;
   logic        pend_q;
   logic        req_q;
   logic [31:0] pc_out_q;
   logic [31:0] instr_q;
   logic        valid_q;
   logic        flush_q;
   logic [31:0] br_target;
   logic        redirect_now;

   // Offset is in words; the top two bits fall off the shift.
   assign br_target = pc_q + {Br_offset[29:0], 2'b00};

   // A branch seen in WAIT without data must wait for the memory to answer.
   assign redirect_now = Br_taken && ((state_q != WAIT) || imem.imem_ready);

`ifdef FETCH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             fetch_err_q;
   assign fetch_err = fetch_err_q;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign fetch_err = 1'b0;
`endif

   logic unused_br_hi;
   assign unused_br_hi = ^Br_offset[31:30];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         pend_target_q <= 32'h0;
         pend_q        <= 1'b0;
         req_q         <= 1'b0;
         pc_out_q      <= RESET_PC;
         instr_q       <= 32'h0;
         valid_q       <= 1'b0;
         flush_q       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         fetch_err_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking updates throughout, so every branch below reads pre-edge state.
         flush_q <= 1'b0;
         if (!stall) valid_q <= 1'b0;

         if (redirect_now) begin
            pc_q    <= br_target;
            pend_q  <= 1'b0;
            flush_q <= 1'b1;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= REQ;
         end else begin
            case (state_q)
               BOOT: begin
                  req_q   <= 1'b1;
                  state_q <= REQ;
               end
               REQ, WAIT: begin
                  if (imem.imem_ready) begin
                     if (pend_q) begin
                        pc_q    <= pend_target_q;
                        pend_q  <= 1'b0;
                        flush_q <= 1'b1;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                     end else begin
                        instr_q  <= imem.imem_rdata;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_q + 32'd4;
                        req_q    <= !stall;
                        state_q  <= stall ? HOLD : REQ;
                     end
                  end else if (Br_taken) begin
                     pend_q        <= 1'b1;
                     pend_target_q <= br_target;
                     valid_q       <= 1'b0;
                  end else if (state_q == REQ) begin
                     state_q <= WAIT;
`ifdef FETCH_TIMEOUT_EN
                     tmo_cnt_q <= '0;
`endif
                  end else begin
`ifdef FETCH_TIMEOUT_EN
                     // Timed out: drop the request for one cycle (via BOOT) and retry.
                     if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        fetch_err_q <= 1'b1;
                        req_q       <= 1'b0;
                        state_q     <= BOOT;
                        if (pend_q) begin
                           pc_q    <= pend_target_q;
                           pend_q  <= 1'b0;
                           flush_q <= 1'b1;
                        end
                     end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                     end
`endif
                  end
               end
               HOLD: begin
                  if (!stall) begin
                     req_q   <= 1'b1;
                     state_q <= REQ;
                  end
               end
            endcase
         end
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign PC             = pc_out_q;
   assign Instruction    = instr_q;
   assign inst_valid     = valid_q;
   assign flush          = flush_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stimulus pushes expected fetches,
// a negedge monitor pops them as the DUT presents new instructions.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        Br_taken = 1'b0;
   logic [31:0] Br_offset = 32'h0;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        inst_valid;
   logic        flush;
   logic        fetch_err;

   fetch_sequencer_if imem_bus();

   fetch_sequencer #(
      .RESET_PC       (32'h0000_0000),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (imem_bus.master),
      .stall       (stall),
      .Br_taken    (Br_taken),
      .Br_offset   (Br_offset),
      .PC          (PC),
      .Instruction (Instruction),
      .inst_valid  (inst_valid),
      .flush       (flush),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_t;

   fetch_t exp_q[$];

   // Memory model: answers after wait_states cycles of an active request.
   int wait_states = 0;
   bit mem_hold    = 1'b0;
   int wcnt        = 0;

   initial begin
      imem_bus.imem_ready = 1'b0;
      imem_bus.imem_rdata = 32'h0;
   end

   always @(negedge clk) begin
      imem_bus.imem_ready = imem_bus.imem_req && !mem_hold && (wcnt >= wait_states);
      imem_bus.imem_rdata = imem_bus.imem_ready ? (imem_bus.imem_addr ^ 32'hA5A5_A5A5)
                                                : 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (rst || !imem_bus.imem_req || imem_bus.imem_ready) wcnt = 0;
      else wcnt = wcnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_fetch(input logic [31:0] addr);
      fetch_t f;
      f.pc    = addr;
      f.instr = addr ^ 32'hA5A5_A5A5;
      exp_q.push_back(f);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: a new instruction is presented unless the previous one was held by stall.
   bit prev_valid = 1'b0;
   bit prev_stall = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (inst_valid && !(prev_valid && prev_stall)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid_pc", PC, 32'hFFFF_FFFF);
            end else begin
               fetch_t f;
               f = exp_q.pop_front();
               check("sb_pc", PC, f.pc);
               check("sb_instr", Instruction, f.instr);
            end
         end
         prev_valid = inst_valid;
         prev_stall = stall;
      end
   end

   initial begin
      // Reset values while rst is held.
      tick(2);
      check("rst_req", imem_bus.imem_req, 1'b0);
      check("rst_pc", PC, 32'h0);
      check("rst_instr", Instruction, 32'h0);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_flush", flush, 1'b0);
      check("rst_err", fetch_err, 1'b0);

      // Zero-wait streaming: captures of 0,4,8,C on edges 2..5.
      for (int a = 0; a < 16; a += 4) push_fetch(a);
      rst = 1'b0;
      check("boot_req", imem_bus.imem_req, 1'b0);
      tick(1);
      check("first_req", imem_bus.imem_req, 1'b1);
      check("first_addr", imem_bus.imem_addr, 32'h0);
      for (int e = 2; e <= 5; e++) begin
         tick(1);
         check("stream_valid", inst_valid, 1'b1);
      end
      check("stream_addr", imem_bus.imem_addr, 32'h10);

      // Three wait states for 0x10, captured under stall.
      wait_states = 3;
      push_fetch(32'h10);
      for (int e = 6; e <= 8; e++) begin
         tick(1);
         check("wait_addr", imem_bus.imem_addr, 32'h10);
         check("wait_req", imem_bus.imem_req, 1'b1);
         check("wait_valid", inst_valid, 1'b0);
      end
      stall = 1'b1;
      for (int e = 9; e <= 13; e++) begin
         tick(1);
         check("hold_req", imem_bus.imem_req, 1'b0);
         check("hold_pc", PC, 32'h10);
         check("hold_instr", Instruction, 32'h10 ^ 32'hA5A5_A5A5);
         check("hold_valid", inst_valid, 1'b1);
      end
      stall = 1'b0;
      tick(1);
      check("release_req", imem_bus.imem_req, 1'b1);
      check("release_addr", imem_bus.imem_addr, 32'h14);
      check("release_valid", inst_valid, 1'b0);

      // Reset in the middle of WAIT.
      mem_hold = 1'b1;
      tick(2);
      rst = 1'b1;
      #1;
      check("midrst_req", imem_bus.imem_req, 1'b0);
      check("midrst_pc", PC, 32'h0);
      check("midrst_valid", inst_valid, 1'b0);
      tick(2);
      mem_hold    = 1'b0;
      wait_states = 0;
      push_fetch(32'h0);
      push_fetch(32'h4);
      rst = 1'b0;
      tick(1);
      check("reboot_addr", imem_bus.imem_addr, 32'h0);
      check("reboot_req", imem_bus.imem_req, 1'b1);
      tick(2);

      // Branch (offset 5) while 0x8 is in WAIT: data discarded, next fetch at 0x1C.
      wait_states = 3;
      tick(1);
      Br_taken  = 1'b1;
      Br_offset = 32'd5;
      tick(1);
      Br_taken = 1'b0;
      check("pend_addr", imem_bus.imem_addr, 32'h8);
      check("pend_flush", flush, 1'b0);
      check("pend_valid", inst_valid, 1'b0);
      tick(1);
      check("pend_flush2", flush, 1'b0);
      check("pend_valid2", inst_valid, 1'b0);
      tick(1);
      check("redir_flush", flush, 1'b1);
      check("redir_addr", imem_bus.imem_addr, 32'h1C);
      check("redir_valid", inst_valid, 1'b0);
      wait_states = 0;
      push_fetch(32'h1C);
      tick(1);
      check("redir_flush_end", flush, 1'b0);

      // Branch and ready in the same REQ cycle; upper offset bits ignored.
      Br_taken  = 1'b1;
      Br_offset = 32'hC000_0002;
      tick(1);
      Br_taken = 1'b0;
      check("brwin_flush", flush, 1'b1);
      check("brwin_valid", inst_valid, 1'b0);
      check("brwin_addr", imem_bus.imem_addr, 32'h28);
      push_fetch(32'h28);
      tick(1);
      check("brwin_flush_end", flush, 1'b0);

      // Negative offset wraps 0x2C back to 0.
      Br_taken  = 1'b1;
      Br_offset = 32'h3FFF_FFF5;
      tick(1);
      Br_taken = 1'b0;
      check("wrap_addr", imem_bus.imem_addr, 32'h0);
      check("wrap_flush", flush, 1'b1);
      push_fetch(32'h0);
      tick(1);

      // Memory stops answering while fetching 0x4.
      mem_hold = 1'b1;
      tick(4);
      check("tmo_pre_err", fetch_err, 1'b0);
      check("tmo_pre_req", imem_bus.imem_req, 1'b1);
      tick(1);
`ifdef FETCH_TIMEOUT_EN
      check("tmo_err", fetch_err, 1'b1);
      check("tmo_drop", imem_bus.imem_req, 1'b0);
      tick(1);
      check("tmo_retry_req", imem_bus.imem_req, 1'b1);
      check("tmo_retry_addr", imem_bus.imem_addr, 32'h4);
      check("tmo_sticky", fetch_err, 1'b1);
`else
      check("notmo_err", fetch_err, 1'b0);
      check("notmo_req", imem_bus.imem_req, 1'b1);
      tick(1);
      check("notmo_addr", imem_bus.imem_addr, 32'h4);
      check("notmo_err2", fetch_err, 1'b0);
`endif
      push_fetch(32'h4);
      mem_hold = 1'b0;
      tick(1);
      mem_hold = 1'b1;
      tick(3);
      check("sb_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
